// File: rtl/parking_gate_sequencer.sv
// Gate terminal: debounces vehicle loops, captures a two-digit code, requests a
// verdict from the parking manager, drives the barrier and enforces lockout.
module parking_gate_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES  = 4,
    parameter int unsigned RESP_TIMEOUT     = 16,
    parameter int unsigned GATE_OPEN_CYCLES = 8,
    parameter int unsigned MAX_TRIES        = 3,
    parameter int unsigned LOCKOUT_CYCLES   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       loop_entry,
    input  logic       loop_exit,
    input  logic       key_valid,
    input  logic [1:0] key_digit,
    input  logic       green_light,
    input  logic       red_light,
    output logic       sense_entry,
    output logic       sense_exit,
    output logic [1:0] password_1,
    output logic [1:0] password_2,
    output logic       gate_open,
    output logic [1:0] retry_count,
    output logic       lockout,
    output logic       timeout
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RESP_W = $clog2(RESP_TIMEOUT + 1);
    localparam int unsigned GATE_W = $clog2(GATE_OPEN_CYCLES + 1);
    localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [RESP_W-1:0] RESP_MAX = RESP_W'(RESP_TIMEOUT);
    localparam logic [GATE_W-1:0] GATE_MAX = GATE_W'(GATE_OPEN_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCKOUT_CYCLES);
    localparam logic [1:0]        TRY_MAX  = 2'(MAX_TRIES);

    typedef enum logic [3:0] {
        IDLE,
        EXIT_PASS,
        WAIT_KEY1,
        WAIT_KEY2,
        ABORT,
        REQUEST,
        OPEN_GATE,
        DENIED,
        LOCKOUT
    } state_t;

    state_t            state;
    logic [DEB_W-1:0]  entry_cnt;
    logic [DEB_W-1:0]  exit_cnt;
    logic [RESP_W-1:0] resp_cnt;
    logic [GATE_W-1:0] gate_cnt;
    logic [LOCK_W-1:0] lock_cnt;

    logic [DEB_W-1:0]  entry_next;
    logic [DEB_W-1:0]  exit_next;
    logic              entry_acc;
    logic              exit_acc;
    logic [RESP_W-1:0] resp_next;
    logic [1:0]        retry_inc;
    logic              gate_done;

    // Saturating debounce counters; a loop is accepted when its count reaches the limit.
    always_comb begin
        entry_next = '0;
        exit_next  = '0;
        if (loop_entry) begin
            entry_next = (entry_cnt == DEB_MAX) ? entry_cnt : entry_cnt + DEB_W'(1);
        end
        if (loop_exit) begin
            exit_next = (exit_cnt == DEB_MAX) ? exit_cnt : exit_cnt + DEB_W'(1);
        end
        entry_acc = (entry_next == DEB_MAX);
        exit_acc  = (exit_next == DEB_MAX);
        resp_next = resp_cnt + RESP_W'(1);
        retry_inc = (retry_count == TRY_MAX) ? retry_count : retry_count + 2'd1;
        gate_done = (gate_cnt == GATE_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            entry_cnt   <= '0;
            exit_cnt    <= '0;
            resp_cnt    <= '0;
            gate_cnt    <= '0;
            lock_cnt    <= '0;
            sense_entry <= 1'b0;
            sense_exit  <= 1'b0;
            password_1  <= 2'd0;
            password_2  <= 2'd0;
            gate_open   <= 1'b0;
            retry_count <= 2'd0;
            lockout     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout   <= 1'b0;
            entry_cnt <= '0;
            exit_cnt  <= '0;
            case (state)
                IDLE: begin
                    entry_cnt <= entry_next;
                    exit_cnt  <= exit_next;
                    if (exit_acc) begin
                        entry_cnt  <= '0;
                        exit_cnt   <= '0;
                        sense_exit <= 1'b1;
                        state      <= EXIT_PASS;
                    end else if (entry_acc) begin
                        entry_cnt <= '0;
                        exit_cnt  <= '0;
                        state     <= WAIT_KEY1;
                    end
                end

                // One-cycle exit notification, then the barrier opens.
                EXIT_PASS: begin
                    if (sense_exit) begin
                        sense_exit <= 1'b0;
                        gate_open  <= 1'b1;
                        gate_cnt   <= GATE_W'(1);
                    end else if (gate_done) begin
                        gate_open <= 1'b0;
                        gate_cnt  <= '0;
                        state     <= IDLE;
                    end else begin
                        gate_cnt <= gate_cnt + GATE_W'(1);
                    end
                end

                WAIT_KEY1: begin
                    if (!loop_entry) begin
                        state <= ABORT;
                    end else if (key_valid) begin
                        password_1 <= key_digit;
                        state      <= WAIT_KEY2;
                    end
                end

                WAIT_KEY2: begin
                    if (!loop_entry) begin
                        state <= ABORT;
                    end else if (key_valid) begin
                        password_2  <= key_digit;
                        sense_entry <= 1'b1;
                        resp_cnt    <= '0;
                        state       <= REQUEST;
                    end
                end

                ABORT: begin
                    password_1  <= 2'd0;
                    password_2  <= 2'd0;
                    retry_count <= 2'd0;
                    state       <= IDLE;
                end

                // Red is checked first so a simultaneous verdict fails safe.
                REQUEST: begin
                    if (red_light) begin
                        sense_entry <= 1'b0;
                        retry_count <= retry_inc;
                        resp_cnt    <= '0;
                        state       <= DENIED;
                    end else if (green_light) begin
                        sense_entry <= 1'b0;
                        gate_open   <= 1'b1;
                        gate_cnt    <= GATE_W'(1);
                        retry_count <= 2'd0;
                        password_1  <= 2'd0;
                        password_2  <= 2'd0;
                        resp_cnt    <= '0;
                        state       <= OPEN_GATE;
                    end else if (resp_next == RESP_MAX) begin
                        timeout     <= 1'b1;
                        sense_entry <= 1'b0;
                        retry_count <= retry_inc;
                        resp_cnt    <= '0;
                        state       <= DENIED;
                    end else begin
                        resp_cnt <= resp_next;
                    end
                end

                OPEN_GATE: begin
                    if (gate_done) begin
                        gate_open <= 1'b0;
                        gate_cnt  <= '0;
                        state     <= IDLE;
                    end else begin
                        gate_cnt <= gate_cnt + GATE_W'(1);
                    end
                end

                DENIED: begin
                    password_1 <= 2'd0;
                    password_2 <= 2'd0;
                    if (retry_count == TRY_MAX) begin
                        lockout  <= 1'b1;
                        lock_cnt <= LOCK_W'(1);
                        state    <= LOCKOUT;
                    end else begin
                        state <= WAIT_KEY1;
                    end
                end

                LOCKOUT: begin
                    if (lock_cnt == LOCK_MAX) begin
                        lockout     <= 1'b0;
                        lock_cnt    <= '0;
                        retry_count <= 2'd0;
                        state       <= IDLE;
                    end else begin
                        lock_cnt <= lock_cnt + LOCK_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// Directed bench for parking_gate_sequencer using an expectation queue.
module tb_parking_gate_sequencer;

    logic       clk;
    logic       rst;
    logic       loop_entry;
    logic       loop_exit;
    logic       key_valid;
    logic [1:0] key_digit;
    logic       green_light;
    logic       red_light;
    logic       sense_entry;
    logic       sense_exit;
    logic [1:0] password_1;
    logic [1:0] password_2;
    logic       gate_open;
    logic [1:0] retry_count;
    logic       lockout;
    logic       timeout;

    parking_gate_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .loop_entry  (loop_entry),
        .loop_exit   (loop_exit),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .green_light (green_light),
        .red_light   (red_light),
        .sense_entry (sense_entry),
        .sense_exit  (sense_exit),
        .password_1  (password_1),
        .password_2  (password_2),
        .gate_open   (gate_open),
        .retry_count (retry_count),
        .lockout     (lockout),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int unsigned val;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input int unsigned v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic observe(input int unsigned obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
        end
    endtask

    task automatic press(input logic [1:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
    endtask

    function automatic int unsigned snap();
        return 32'({sense_entry, sense_exit, password_1, password_2,
                    gate_open, retry_count, lockout, timeout});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        int unsigned seen;

        rst = 1'b0; loop_entry = 1'b0; loop_exit = 1'b0; key_valid = 1'b0;
        key_digit = 2'd0; green_light = 1'b0; red_light = 1'b0;

        // Reset
        expect_val("reset_all_zero", 0);
        tick(); tick();
        observe(snap());
        expect_val("idle_after_reset", 0);
        rst = 1'b1;
        repeat (3) tick();
        observe(snap());

        // Entry grant
        expect_val("no_sense_in_wait_key1", 0);
        loop_entry = 1'b1;
        repeat (6) tick();
        observe(32'(sense_entry));
        expect_val("no_sense_after_key1", 0);
        press(2'd1);
        observe(32'(sense_entry));
        expect_val("sense_entry_after_key2", 1);
        expect_val("passwords_01_01", 5);
        press(2'd1);
        observe(32'(sense_entry));
        observe(32'({password_1, password_2}));
        expect_val("sense_held_no_gate", 2);
        repeat (3) tick();
        observe(32'({sense_entry, gate_open}));
        expect_val("grant_sense_drop_gate_up", 1);
        expect_val("grant_gate_cycles", 8);
        expect_val("grant_retry_zero", 0);
        green_light = 1'b1;
        tick();
        green_light = 1'b0;
        loop_entry  = 1'b0;
        observe(32'({sense_entry, gate_open}));
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (!gate_open) break;
            n++;
            tick();
        end
        observe(n);
        observe(32'(retry_count));

        // Three denials then lockout
        loop_entry = 1'b1;
        repeat (6) tick();
        for (int s = 1; s <= 3; s++) begin
            press(2'd2);
            press(2'd3);
            repeat (2) tick();
            expect_val("deny_retry_count", 32'(s));
            red_light = 1'b1;
            tick();
            red_light = 1'b0;
            observe(32'(retry_count));
            tick();
        end
        expect_val("lockout_cycles", 32);
        expect_val("post_lockout_retry_zero", 0);
        expect_val("post_lockout_quiet", 0);
        loop_entry = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (!lockout) break;
            n++;
            key_valid = (i % 8 == 3);
            key_digit = 2'd3;
            tick();
        end
        key_valid = 1'b0;
        observe(n);
        observe(32'(retry_count));
        repeat (6) tick();
        observe(32'({sense_entry, sense_exit, gate_open, lockout}));

        // Timeout then simultaneous verdict
        loop_entry = 1'b1;
        repeat (6) tick();
        press(2'd1);
        press(2'd2);
        expect_val("timeout_latency", 16);
        expect_val("timeout_retry_one", 1);
        expect_val("timeout_one_cycle", 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (timeout) break;
            n++;
            tick();
        end
        observe(n);
        observe(32'(retry_count));
        tick();
        observe(32'(timeout));
        press(2'd3);
        press(2'd0);
        tick();
        expect_val("conflict_gate_stays_low", 0);
        expect_val("conflict_retry_two", 2);
        green_light = 1'b1;
        red_light   = 1'b1;
        tick();
        green_light = 1'b0;
        red_light   = 1'b0;
        seen = 0;
        repeat (10) begin
            seen = seen | 32'(gate_open);
            tick();
        end
        observe(seen);
        observe(32'(retry_count));
        expect_val("abort_clears_retry", 0);
        loop_entry = 1'b0;
        repeat (3) tick();
        observe(32'(retry_count));

        // Both detectors together: exit wins
        expect_val("no_exit_before_debounce", 0);
        expect_val("sense_exit_pulse", 1);
        expect_val("exit_gate_after_pulse", 1);
        expect_val("exit_gate_cycles", 8);
        loop_entry = 1'b1;
        loop_exit  = 1'b1;
        repeat (3) tick();
        observe(32'(sense_exit));
        tick();
        observe(32'({sense_exit, gate_open, sense_entry}) == 32'b100 ? 1 : 0);
        loop_entry = 1'b0;
        loop_exit  = 1'b0;
        tick();
        observe(32'({sense_exit, gate_open}));
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (!gate_open) break;
            n++;
            tick();
        end
        observe(n);

        // Short loop glitch is rejected
        expect_val("glitch_no_response", 0);
        loop_exit = 1'b1;
        repeat (3) tick();
        loop_exit = 1'b0;
        seen = 0;
        repeat (12) begin
            seen = seen | 32'({sense_exit, gate_open});
            tick();
        end
        observe(seen);

        // Vehicle leaves after first key
        loop_entry = 1'b1;
        repeat (6) tick();
        expect_val("key1_captured", 2);
        expect_val("abort_clears_passwords", 0);
        expect_val("idle_key_ignored", 0);
        press(2'd2);
        observe(32'(password_1));
        loop_entry = 1'b0;
        repeat (2) tick();
        observe(32'({password_1, password_2}));
        press(2'd3);
        repeat (2) tick();
        observe(32'({password_1, password_2}));

        // Reset during a pending request
        loop_entry = 1'b1;
        repeat (6) tick();
        press(2'd1);
        press(2'd2);
        expect_val("request_pending", 1);
        expect_val("reset_mid_request", 0);
        expect_val("idle_after_second_reset", 0);
        repeat (2) tick();
        observe(32'(sense_entry));
        rst        = 1'b0;
        loop_entry = 1'b0;
        tick();
        observe(snap());
        rst = 1'b1;
        repeat (3) tick();
        observe(snap());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
